decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/instruction_utils_pkg.sv | 59 +++++
 rtl/instr_decode_core.sv | 156 +++++++++++++++
 rtl/decode_stage.sv | 166 ++++++++++++++++
 tb/tb_decode_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_utils_pkg.sv
// Shared RV32I(+M, +system) instruction vocabulary: decoded instruction kinds,
// major opcodes and the funct fields the decoder keys on.
package instruction_utils;

  typedef enum logic [5:0] {
    INSTR_ILLEGAL,
    INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
    INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
    INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
    INSTR_SB, INSTR_SH, INSTR_SW,
    INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
    INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
    INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
    INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND,
    INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU,
    INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU,
    INSTR_FENCE, INSTR_ECALL, INSTR_EBREAK
  } rv32i_instr_e;

  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  localparam logic [31:0] INSTR_WORD_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_WORD_EBREAK = 32'h0010_0073;

  // Branches, stores, fences and traps never produce a register result.
  function automatic logic writes_rd(input rv32i_instr_e t);
    case (t)
      INSTR_ILLEGAL,
      INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
      INSTR_SB, INSTR_SH, INSTR_SW,
      INSTR_FENCE, INSTR_ECALL, INSTR_EBREAK: return 1'b0;
      default:                                return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_core.sv
// Purely combinational RV32I decoder; M and system instructions are
// recognised only when their enables are set, otherwise reported illegal.
module instr_decode_core
  import instruction_utils::*;
#(
  parameter bit ENABLE_M      = 1'b0,
  parameter bit ENABLE_SYSTEM = 1'b0
) (
  input  logic [31:0]  instr,
  output logic [4:0]   rs1,
  output logic [4:0]   rs2,
  output logic [4:0]   rd,
  output logic [31:0]  imm,
  output logic         rd_write_en,
  output rv32i_instr_e instr_type,
  output logic         illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    instr_type = INSTR_ILLEGAL;
    if (instr[1:0] == 2'b11) begin
      case (opcode)
        OPCODE_LUI:   instr_type = INSTR_LUI;
        OPCODE_AUIPC: instr_type = INSTR_AUIPC;
        OPCODE_JAL:   instr_type = INSTR_JAL;
        OPCODE_JALR:  if (funct3 == 3'b000) instr_type = INSTR_JALR;
        OPCODE_BRANCH: begin
          case (funct3)
            3'b000:  instr_type = INSTR_BEQ;
            3'b001:  instr_type = INSTR_BNE;
            3'b100:  instr_type = INSTR_BLT;
            3'b101:  instr_type = INSTR_BGE;
            3'b110:  instr_type = INSTR_BLTU;
            3'b111:  instr_type = INSTR_BGEU;
            default: instr_type = INSTR_ILLEGAL;
          endcase
        end
        OPCODE_LOAD: begin
          case (funct3)
            3'b000:  instr_type = INSTR_LB;
            3'b001:  instr_type = INSTR_LH;
            3'b010:  instr_type = INSTR_LW;
            3'b100:  instr_type = INSTR_LBU;
            3'b101:  instr_type = INSTR_LHU;
            default: instr_type = INSTR_ILLEGAL;
          endcase
        end
        OPCODE_STORE: begin
          case (funct3)
            3'b000:  instr_type = INSTR_SB;
            3'b001:  instr_type = INSTR_SH;
            3'b010:  instr_type = INSTR_SW;
            default: instr_type = INSTR_ILLEGAL;
          endcase
        end
        OPCODE_OP_IMM: begin
          case (funct3)
            3'b000: instr_type = INSTR_ADDI;
            3'b010: instr_type = INSTR_SLTI;
            3'b011: instr_type = INSTR_SLTIU;
            3'b100: instr_type = INSTR_XORI;
            3'b110: instr_type = INSTR_ORI;
            3'b111: instr_type = INSTR_ANDI;
            3'b001: if (funct7 == FUNCT7_BASE) instr_type = INSTR_SLLI;
            default: begin
              // funct3 101: logical vs arithmetic right shift by funct7
              if (funct7 == FUNCT7_BASE)     instr_type = INSTR_SRLI;
              else if (funct7 == FUNCT7_ALT) instr_type = INSTR_SRAI;
            end
          endcase
        end
        OPCODE_OP: begin
          if (funct7 == FUNCT7_BASE) begin
            case (funct3)
              3'b000:  instr_type = INSTR_ADD;
              3'b001:  instr_type = INSTR_SLL;
              3'b010:  instr_type = INSTR_SLT;
              3'b011:  instr_type = INSTR_SLTU;
              3'b100:  instr_type = INSTR_XOR;
              3'b101:  instr_type = INSTR_SRL;
              3'b110:  instr_type = INSTR_OR;
              default: instr_type = INSTR_AND;
            endcase
          end else if (funct7 == FUNCT7_ALT) begin
            if (funct3 == 3'b000)      instr_type = INSTR_SUB;
            else if (funct3 == 3'b101) instr_type = INSTR_SRA;
          end else if (funct7 == FUNCT7_MULDIV && ENABLE_M) begin
            case (funct3)
              FUNCT3_MUL:    instr_type = INSTR_MUL;
              FUNCT3_MULH:   instr_type = INSTR_MULH;
              FUNCT3_MULHSU: instr_type = INSTR_MULHSU;
              FUNCT3_MULHU:  instr_type = INSTR_MULHU;
              FUNCT3_DIV:    instr_type = INSTR_DIV;
              FUNCT3_DIVU:   instr_type = INSTR_DIVU;
              FUNCT3_REM:    instr_type = INSTR_REM;
              default:       instr_type = INSTR_REMU;
            endcase
          end
        end
        OPCODE_MISC_MEM: if (ENABLE_SYSTEM && funct3 == 3'b000) instr_type = INSTR_FENCE;
        OPCODE_SYSTEM: begin
          // Only the two exact trap encodings are supported; CSR ops are not.
          if (ENABLE_SYSTEM && instr == INSTR_WORD_ECALL)  instr_type = INSTR_ECALL;
          if (ENABLE_SYSTEM && instr == INSTR_WORD_EBREAK) instr_type = INSTR_EBREAK;
        end
        default: instr_type = INSTR_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    case (instr_type)
      INSTR_JALR, INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
      INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI:
        imm = imm_i;
      INSTR_SLLI, INSTR_SRLI, INSTR_SRAI:
        imm = {27'd0, instr[24:20]};
      INSTR_SB, INSTR_SH, INSTR_SW:
        imm = imm_s;
      INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU:
        imm = imm_b;
      INSTR_LUI, INSTR_AUIPC:
        imm = imm_u;
      INSTR_JAL:
        imm = imm_j;
      default:
        imm = 32'd0;
    endcase
  end

  assign illegal     = (instr_type == INSTR_ILLEGAL);
  assign rd_write_en = writes_rd(instr_type) && (instr[11:7] != 5'd0);
  assign rs1         = illegal ? 5'd0 : instr[19:15];
  assign rs2         = illegal ? 5'd0 : instr[24:20];
  assign rd          = illegal ? 5'd0 : instr[11:7];

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decodes on entry, then holds results in an output
// register backed by a one-entry skid register so in_ready can be a flop.
module decode_stage
  import instruction_utils::*;
#(
  parameter bit ENABLE_M      = 1'b0,
  parameter bit ENABLE_SYSTEM = 1'b0,
  parameter int PC_WIDTH      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [31:0]         out_imm,
  output logic                out_rd_write_en,
  output logic [PC_WIDTH-1:0] out_pc,
  output rv32i_instr_e        out_instr_type,
  output logic                out_illegal,
  output logic [15:0]         illegal_count
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  typedef struct packed {
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [31:0]         imm;
    logic                rd_write_en;
    rv32i_instr_e        instr_type;
    logic                illegal;
    logic [PC_WIDTH-1:0] pc;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0, rd_write_en: 1'b0,
    instr_type: INSTR_ILLEGAL, illegal: 1'b0, pc: '0
  };

  state_e       state_q, state_d;
  entry_t       out_entry_q, out_entry_d;
  entry_t       skid_entry_q, skid_entry_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [15:0]  illegal_count_q, illegal_count_d;

  entry_t       new_entry;
  logic [4:0]   dec_rs1, dec_rs2, dec_rd;
  logic [31:0]  dec_imm;
  logic         dec_rd_write_en, dec_illegal;
  rv32i_instr_e dec_instr_type;
  logic         in_xfer, out_xfer;

  instr_decode_core #(
    .ENABLE_M      (ENABLE_M),
    .ENABLE_SYSTEM (ENABLE_SYSTEM)
  ) u_core (
    .instr       (in_instr),
    .rs1         (dec_rs1),
    .rs2         (dec_rs2),
    .rd          (dec_rd),
    .imm         (dec_imm),
    .rd_write_en (dec_rd_write_en),
    .instr_type  (dec_instr_type),
    .illegal     (dec_illegal)
  );

  always_comb begin
    new_entry             = ENTRY_RESET;
    new_entry.rs1         = dec_rs1;
    new_entry.rs2         = dec_rs2;
    new_entry.rd          = dec_rd;
    new_entry.imm         = dec_imm;
    new_entry.rd_write_en = dec_rd_write_en;
    new_entry.instr_type  = dec_instr_type;
    new_entry.illegal     = dec_illegal;
    new_entry.pc          = in_pc;
  end

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    state_d         = state_q;
    out_entry_d     = out_entry_q;
    skid_entry_d    = skid_entry_q;
    illegal_count_d = illegal_count_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            out_entry_d = new_entry;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            out_entry_d = new_entry;
          end else if (in_xfer) begin
            skid_entry_d = new_entry;
            state_d      = ST_TWO;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the output side can move.
          if (out_xfer) begin
            out_entry_d = skid_entry_q;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase

      if (out_xfer && out_entry_q.illegal && illegal_count_q != 16'hFFFF) begin
        illegal_count_d = illegal_count_q + 16'd1;
      end
    end

    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_EMPTY;
      out_entry_q     <= ENTRY_RESET;
      skid_entry_q    <= ENTRY_RESET;
      in_ready_q      <= 1'b1;
      out_valid_q     <= 1'b0;
      illegal_count_q <= 16'd0;
    end else begin
      state_q         <= state_d;
      out_entry_q     <= out_entry_d;
      skid_entry_q    <= skid_entry_d;
      in_ready_q      <= in_ready_d;
      out_valid_q     <= out_valid_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_rs1         = out_entry_q.rs1;
  assign out_rs2         = out_entry_q.rs2;
  assign out_rd          = out_entry_q.rd;
  assign out_imm         = out_entry_q.imm;
  assign out_rd_write_en = out_entry_q.rd_write_en;
  assign out_pc          = out_entry_q.pc;
  assign out_instr_type  = out_entry_q.instr_type;
  assign out_illegal     = out_entry_q.illegal;
  assign illegal_count   = illegal_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (base, and M+system enabled) share one
// stimulus stream and are compared each cycle against a queue/table model.
module tb_decode_stage;
  import instruction_utils::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic         o0_in_ready, o0_out_valid, o0_we, o0_ill;
  logic [4:0]   o0_rs1, o0_rs2, o0_rd;
  logic [31:0]  o0_imm, o0_pc;
  rv32i_instr_e o0_type;
  logic [15:0]  o0_cnt;

  logic         o1_in_ready, o1_out_valid, o1_we, o1_ill;
  logic [4:0]   o1_rs1, o1_rs2, o1_rd;
  logic [31:0]  o1_imm, o1_pc;
  rv32i_instr_e o1_type;
  logic [15:0]  o1_cnt;

  always #5 clk = ~clk;

  decode_stage #(.ENABLE_M(1'b0), .ENABLE_SYSTEM(1'b0), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o0_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(o0_out_valid), .out_ready(out_ready),
    .out_rs1(o0_rs1), .out_rs2(o0_rs2), .out_rd(o0_rd), .out_imm(o0_imm),
    .out_rd_write_en(o0_we), .out_pc(o0_pc), .out_instr_type(o0_type),
    .out_illegal(o0_ill), .illegal_count(o0_cnt)
  );

  decode_stage #(.ENABLE_M(1'b1), .ENABLE_SYSTEM(1'b1), .PC_WIDTH(32)) dut_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o1_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(o1_out_valid), .out_ready(out_ready),
    .out_rs1(o1_rs1), .out_rs2(o1_rs2), .out_rd(o1_rd), .out_imm(o1_imm),
    .out_rd_write_en(o1_we), .out_pc(o1_pc), .out_instr_type(o1_type),
    .out_illegal(o1_ill), .illegal_count(o1_cnt)
  );

  int checks = 0;
  int failures = 0;
  bit verbose = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference decoder: mask/match table ----------------
  typedef struct {
    rv32i_instr_e t;
    logic         ill;
    logic [4:0]   rs1, rs2, rd;
    logic [31:0]  imm;
    logic         we;
  } exp_t;

  logic [31:0]  tab_mask  [64];
  logic [31:0]  tab_match [64];
  rv32i_instr_e tab_type  [64];
  byte          tab_fmt   [64];
  int           tab_grp   [64];   // 0 base, 1 needs M, 2 needs system
  int           n_tab = 0;

  task automatic add_op(input logic [31:0] mask, input logic [31:0] match,
                        input rv32i_instr_e t, input byte f, input int g);
    tab_mask[n_tab] = mask; tab_match[n_tab] = match;
    tab_type[n_tab] = t; tab_fmt[n_tab] = f; tab_grp[n_tab] = g;
    n_tab++;
  endtask

  task automatic build_table();
    add_op(32'h7F, 32'h37, INSTR_LUI, "U", 0);
    add_op(32'h7F, 32'h17, INSTR_AUIPC, "U", 0);
    add_op(32'h7F, 32'h6F, INSTR_JAL, "J", 0);
    add_op(32'h707F, 32'h67, INSTR_JALR, "I", 0);
    add_op(32'h707F, 32'h0063, INSTR_BEQ, "B", 0);
    add_op(32'h707F, 32'h1063, INSTR_BNE, "B", 0);
    add_op(32'h707F, 32'h4063, INSTR_BLT, "B", 0);
    add_op(32'h707F, 32'h5063, INSTR_BGE, "B", 0);
    add_op(32'h707F, 32'h6063, INSTR_BLTU, "B", 0);
    add_op(32'h707F, 32'h7063, INSTR_BGEU, "B", 0);
    add_op(32'h707F, 32'h0003, INSTR_LB, "I", 0);
    add_op(32'h707F, 32'h1003, INSTR_LH, "I", 0);
    add_op(32'h707F, 32'h2003, INSTR_LW, "I", 0);
    add_op(32'h707F, 32'h4003, INSTR_LBU, "I", 0);
    add_op(32'h707F, 32'h5003, INSTR_LHU, "I", 0);
    add_op(32'h707F, 32'h0023, INSTR_SB, "S", 0);
    add_op(32'h707F, 32'h1023, INSTR_SH, "S", 0);
    add_op(32'h707F, 32'h2023, INSTR_SW, "S", 0);
    add_op(32'h707F, 32'h0013, INSTR_ADDI, "I", 0);
    add_op(32'h707F, 32'h2013, INSTR_SLTI, "I", 0);
    add_op(32'h707F, 32'h3013, INSTR_SLTIU, "I", 0);
    add_op(32'h707F, 32'h4013, INSTR_XORI, "I", 0);
    add_op(32'h707F, 32'h6013, INSTR_ORI, "I", 0);
    add_op(32'h707F, 32'h7013, INSTR_ANDI, "I", 0);
    add_op(32'hFE00707F, 32'h00001013, INSTR_SLLI, "H", 0);
    add_op(32'hFE00707F, 32'h00005013, INSTR_SRLI, "H", 0);
    add_op(32'hFE00707F, 32'h40005013, INSTR_SRAI, "H", 0);
    add_op(32'hFE00707F, 32'h00000033, INSTR_ADD, "R", 0);
    add_op(32'hFE00707F, 32'h40000033, INSTR_SUB, "R", 0);
    add_op(32'hFE00707F, 32'h00001033, INSTR_SLL, "R", 0);
    add_op(32'hFE00707F, 32'h00002033, INSTR_SLT, "R", 0);
    add_op(32'hFE00707F, 32'h00003033, INSTR_SLTU, "R", 0);
    add_op(32'hFE00707F, 32'h00004033, INSTR_XOR, "R", 0);
    add_op(32'hFE00707F, 32'h00005033, INSTR_SRL, "R", 0);
    add_op(32'hFE00707F, 32'h40005033, INSTR_SRA, "R", 0);
    add_op(32'hFE00707F, 32'h00006033, INSTR_OR, "R", 0);
    add_op(32'hFE00707F, 32'h00007033, INSTR_AND, "R", 0);
    add_op(32'hFE00707F, 32'h02000033, INSTR_MUL, "R", 1);
    add_op(32'hFE00707F, 32'h02001033, INSTR_MULH, "R", 1);
    add_op(32'hFE00707F, 32'h02002033, INSTR_MULHSU, "R", 1);
    add_op(32'hFE00707F, 32'h02003033, INSTR_MULHU, "R", 1);
    add_op(32'hFE00707F, 32'h02004033, INSTR_DIV, "R", 1);
    add_op(32'hFE00707F, 32'h02005033, INSTR_DIVU, "R", 1);
    add_op(32'hFE00707F, 32'h02006033, INSTR_REM, "R", 1);
    add_op(32'hFE00707F, 32'h02007033, INSTR_REMU, "R", 1);
    add_op(32'h707F, 32'h000F, INSTR_FENCE, "N", 2);
    add_op(32'hFFFFFFFF, 32'h00000073, INSTR_ECALL, "N", 2);
    add_op(32'hFFFFFFFF, 32'h00100073, INSTR_EBREAK, "N", 2);
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w, input bit en_m, input bit en_sys);
    exp_t        e;
    bit          hit = 1'b0;
    byte         f = "N";
    logic [31:0] sgn;
    e.t = INSTR_ILLEGAL; e.ill = 1'b1; e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.imm = '0; e.we = 1'b0;
    for (int k = 0; k < n_tab; k++) begin
      if (!hit && (w & tab_mask[k]) == tab_match[k] &&
          (tab_grp[k] == 0 || (tab_grp[k] == 1 && en_m) || (tab_grp[k] == 2 && en_sys))) begin
        hit = 1'b1; e.t = tab_type[k]; f = tab_fmt[k];
      end
    end
    if (hit) begin
      sgn = w[31] ? 32'hFFFF_FFFF : 32'h0;
      e.ill = 1'b0; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
      case (f)
        "I": e.imm = 32'($signed(w) >>> 20);
        "H": e.imm = (w >> 20) & 32'h1F;
        "S": e.imm = (32'($signed(w) >>> 20) & ~32'h1F) | ((w >> 7) & 32'h1F);
        "B": e.imm = (sgn << 12) | (((w >> 7) & 32'h1) << 11) |
                     (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
        "U": e.imm = w & 32'hFFFF_F000;
        "J": e.imm = (sgn << 20) | (w & 32'h000F_F000) |
                     (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
        default: e.imm = 32'h0;
      endcase
      e.we = (f == "U" || f == "J" || f == "I" || f == "H" || f == "R") && (w[11:7] != 5'd0);
    end
    return e;
  endfunction

  // ---------------- handshake model: FIFO of at most two entries ----------------
  typedef struct { logic [31:0] instr; logic [31:0] pc; } item_t;
  item_t       mq[$];
  logic [15:0] cnt0 = 0, cnt1 = 0;

  task automatic model_edge();
    bit   o, i;
    exp_t e0, e1;
    if (rst) begin
      mq.delete(); cnt0 = 0; cnt1 = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      o = (mq.size() > 0) && out_ready;
      i = in_valid && (mq.size() < 2);
      if (o) begin
        e0 = ref_decode(mq[0].instr, 1'b0, 1'b0);
        e1 = ref_decode(mq[0].instr, 1'b1, 1'b1);
        if (e0.ill && cnt0 != 16'hFFFF) cnt0++;
        if (e1.ill && cnt1 != 16'hFFFF) cnt1++;
        if (verbose) $display("xfer pc=%08h instr=%08h base=%s full=%s",
                              mq[0].pc, mq[0].instr, e0.t.name(), e1.t.name());
        void'(mq.pop_front());
      end
      if (i) mq.push_back('{instr: in_instr, pc: in_pc});
    end
  endtask

  task automatic compare_one(input string nm, input bit en,
      input logic rdy, input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [4:0] rd, input logic [31:0] imm, input logic we, input logic [31:0] pc,
      input logic [5:0] typ, input logic ill, input logic [15:0] cnt, input logic [15:0] cnt_exp);
    exp_t e;
    check({nm, ".in_ready"}, 64'(rdy), 64'(mq.size() < 2));
    check({nm, ".out_valid"}, 64'(vld), 64'(mq.size() > 0));
    check({nm, ".illegal_count"}, 64'(cnt), 64'(cnt_exp));
    if (mq.size() > 0) begin
      e = ref_decode(mq[0].instr, en, en);
      check({nm, ".type"}, 64'(typ), 64'(e.t));
      check({nm, ".illegal"}, 64'(ill), 64'(e.ill));
      check({nm, ".rs1"}, 64'(rs1), 64'(e.rs1));
      check({nm, ".rs2"}, 64'(rs2), 64'(e.rs2));
      check({nm, ".rd"}, 64'(rd), 64'(e.rd));
      check({nm, ".imm"}, 64'(imm), 64'(e.imm));
      check({nm, ".we"}, 64'(we), 64'(e.we));
      check({nm, ".pc"}, 64'(pc), 64'(mq[0].pc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_one("base", 1'b0, o0_in_ready, o0_out_valid, o0_rs1, o0_rs2, o0_rd, o0_imm,
                o0_we, o0_pc, o0_type, o0_ill, o0_cnt, cnt0);
    compare_one("full", 1'b1, o1_in_ready, o1_out_valid, o1_rs1, o1_rs2, o1_rd, o1_imm,
                o1_we, o1_pc, o1_type, o1_ill, o1_cnt, cnt1);
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc);
    in_valid = v; in_instr = w; in_pc = pc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [11];
    int unsigned s;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w = $urandom;
    s = $urandom_range(0, 19);
    if (s < 11) w[6:0] = ops[s];
    else if (s < 15) begin
      w[6:0] = (s < 13) ? 7'h33 : 7'h13;
      case ($urandom_range(0, 2))
        0:       w[31:25] = 7'h00;
        1:       w[31:25] = 7'h20;
        default: w[31:25] = 7'h01;
      endcase
    end
    else if (s == 15) w = 32'h0000_0073;
    else if (s == 16) w = 32'h0010_0073;
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    build_table();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick(); tick();

    // reset state
    check("rst.out_valid", 64'(o0_out_valid), 64'd0);
    check("rst.in_ready", 64'(o0_in_ready), 64'd1);
    check("rst.type", 64'(o0_type), 64'(INSTR_ILLEGAL));
    check("rst.illegal", 64'(o0_ill), 64'd0);
    check("rst.imm", 64'(o0_imm), 64'd0);
    check("rst.regs", 64'({o0_rs1, o0_rs2, o0_rd, o0_we}), 64'd0);
    check("rst.pc", 64'(o0_pc), 64'd0);
    check("rst.count", 64'(o1_cnt), 64'd0);
    rst = 1'b0;

    // back-to-back ADDI then SRAI
    out_ready = 1'b1;
    drive(1'b1, 32'hFFB00093, 32'h100); tick();
    check("b2b.type0", 64'(o0_type), 64'(INSTR_ADDI));
    check("b2b.imm0", 64'(o0_imm), 64'hFFFFFFFB);
    drive(1'b1, 32'h4030D113, 32'h104); tick();
    check("b2b.type1", 64'(o0_type), 64'(INSTR_SRAI));
    check("b2b.imm1", 64'(o0_imm), 64'h3);
    check("b2b.valid1", 64'(o0_out_valid), 64'd1);
    drive(1'b0, 32'h0, 32'h0); tick();
    check("b2b.drain", 64'(o0_out_valid), 64'd0);

    // stall with three pushes; third waits for the skid to drain
    out_ready = 1'b0;
    drive(1'b1, 32'hFFB00093, 32'h200); tick();
    check("stall.rdy1", 64'(o0_in_ready), 64'd1);
    drive(1'b1, 32'h4030D113, 32'h204); tick();
    check("stall.rdy2", 64'(o0_in_ready), 64'd0);
    drive(1'b1, 32'h00208033, 32'h208); tick();
    check("stall.hold_pc", 64'(o0_pc), 64'h200);
    check("stall.rdy3", 64'(o0_in_ready), 64'd0);
    out_ready = 1'b1; tick();
    check("stall.second_pc", 64'(o0_pc), 64'h204);
    tick();
    check("stall.third_pc", 64'(o0_pc), 64'h208);
    check("rd0.type", 64'(o0_type), 64'(INSTR_ADD));
    check("rd0.we", 64'(o0_we), 64'd0);
    drive(1'b0, 32'h0, 32'h0); tick();
    check("stall.empty", 64'(o0_out_valid), 64'd0);

    // flush while full with an input offered
    out_ready = 1'b0;
    drive(1'b1, 32'h00208033, 32'h300); tick();
    drive(1'b1, 32'h00208033, 32'h304); tick();
    flush = 1'b1;
    drive(1'b1, 32'hFFB00093, 32'hDEAD0); tick();
    check("flush.valid", 64'(o0_out_valid), 64'd0);
    check("flush.ready", 64'(o0_in_ready), 64'd1);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush.no_emerge", 64'(o0_out_valid), 64'd0);
    end

    // MUL: illegal without M, decoded with M
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b1, 32'h022081B3, 32'h400); tick();
    check("mul.base_ill", 64'(o0_ill), 64'd1);
    check("mul.full_type", 64'(o1_type), 64'(INSTR_MUL));
    check("mul.full_we", 64'(o1_we), 64'd1);
    drive(1'b0, 32'h0, 32'h0); tick();
    check("mul.base_cnt", 64'(o0_cnt), 64'd1);
    check("mul.full_cnt", 64'(o1_cnt), 64'd0);

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      rst       = ($urandom_range(0, 499) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom);
      tick();
    end
    rst = 1'b0; flush = 1'b0;

    // saturation: 65537 illegal transfers
    rst = 1'b1; tick(); rst = 1'b0;
    verbose = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h0, 32'h500);
    for (int k = 0; k < 65538; k++) tick();
    check("sat.base", 64'(o0_cnt), 64'hFFFF);
    check("sat.full", 64'(o1_cnt), 64'hFFFF);
    drive(1'b0, 32'h0, 32'h0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("sat.reset", 64'(o0_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
